ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the opposite direction of the keyboard receive path.
- Sends one command byte from the PicoBlaze to the keyboard, e.g. ED set-LEDs, F4 enable, FF reset.
- Generates the request-to-send sequence, shifts out the frame on device-generated clocks and checks the device ACK.
- Sits beside the Keyboard receiver on the same PS/2 pins and shares the PicoBlaze port bus. Tx_Busy tells the receiver to ignore line activity.

Parameters:
- INHIBIT_CYCLES, 10000: CLK cycles PS2 clock is held low (100 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: max CLK cycles from clock release to ACK sampled (15 ms).
- PORT_DATA, 8'h08: Port_ID whose write starts a transmission.
- PORT_STATUS, 8'h09: Port_ID for the status read.
- SYNC_STAGES, 2: synchronizer depth on PS2 inputs.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-low reset.
- Port_ID  in  8  PicoBlaze port address.
- Write_Strobe  in  1  PicoBlaze write strobe, one cycle.
- Out_Port  in  8  PicoBlaze write data.
- Read_Strobe  in  1  PicoBlaze read strobe, one cycle.
- Status_Output  out  8  registered status byte.
- PS2_Clock_In  in  1  PS2 clock pin level (asynchronous).
- PS2_Data_In  in  1  PS2 data pin level (asynchronous).
- PS2_Clock_Drive_Low  out  1  1 = pull PS2 clock low (open-drain enable).
- PS2_Data_Drive_Low  out  1  1 = pull PS2 data low.
- Tx_Busy  out  1  1 while the FSM is not IDLE.

Behaviour:
- Reset (RESET=0, asynchronous): both Drive_Low outputs 0 (lines released), Tx_Busy 0, Status_Output 8'h00, all sticky bits 0, FSM IDLE. A reset mid-frame releases both lines immediately.
- Inputs: PS2 clock and data pass through SYNC_STAGES flops. Falling edge = previous synchronized clock 1, current 0.
- Start: Write_Strobe=1 with Port_ID==PORT_DATA in IDLE latches Out_Port and goes to INHIBIT on the next cycle.
- Write while busy: the write is ignored and the overrun bit is set.
- IDLE: lines released.
- INHIBIT: Clock_Drive_Low=1 for exactly INHIBIT_CYCLES. Data_Drive_Low=1 asserted in the last cycle of this state.
- RTS: clock released, data held low (start bit), timeout counter starts.
- DATA: on each falling edge the host drives the next bit on data, LSB first.
  - Falling edges 1..8: data bits 0..7.
  - Falling edge 9: odd parity (XOR of the byte inverted).
  - Drive_Low = ~bit.
- STOP: on falling edge 10, data is released.
- ACK: on falling edge 11, sample data.
  - 0: go to WAIT_IDLE.
  - 1: set ack_err, go to WAIT_IDLE.
- WAIT_IDLE: wait until both synchronized lines are 1, then set done and go to IDLE.
- Timeout: counter reaches TIMEOUT_CYCLES in RTS/DATA/STOP/ACK → release both lines, set timeout, go to IDLE.
- Status_Output: registered every cycle. Value is the status byte when Port_ID==PORT_STATUS, else 8'h00.
  - bit0 busy (live), bit1 done, bit2 ack_err, bit3 timeout, bit4 overrun, bits7:5 = 0.
- Clear-on-read: bits 4:1 are sticky. Read_Strobe with Port_ID==PORT_STATUS clears them one cycle after the read; the byte registered in the read cycle still shows them.
- Simultaneous set and clear in one cycle: set wins.
- A new transmission clears done/ack_err/timeout at INHIBIT entry.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined: on NACK or timeout the FSM reloads the latched byte and restarts at INHIBIT once. ack_err/timeout are set only if the retry also fails. Status bit5 = retried, sticky, clear-on-read.
- Undefined: no retry, and bit5 is always 0.

Test Plan:
- Reset mid-INHIBIT: RESET low while Clock_Drive_Low=1 → both Drive_Low outputs 0 in the same timestep, Status_Output 8'h00.
- Write 8'hED to 8'h08 with a device model clocking 30 us half-periods and ACKing → clock low for 10000 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop released. Status read on 8'h09 returns 8'h02, the next read returns 8'h00.
- Write 8'hF4 → data bits 0,0,1,0,1,1,1,1, parity 0; Tx_Busy high from the cycle after Write_Strobe until both lines idle high.
- Device holds data high at falling edge 11 → status 8'h04 (without PS2_TX_RETRY_EN).
- Device never clocks after RTS → after 1500000 cycles both lines released; status 8'h08.
- Second write of 8'hFF during busy → frame of ED unaffected; status after completion 8'h12.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte written by the PicoBlaze (for example ED set-LEDs,
// F4 enable, FF reset) to the PS/2 device. The sequence is: hold the clock low
// (inhibit), hold data low (request-to-send), shift out the frame on the
// device-generated falling edges, check the device ACK, then wait for the bus
// to return to idle.
//
// Optional feature macro: PS2_TX_RETRY_EN. When it is defined, a NACK or a
// timeout restarts the frame once from INHIBIT, and status bit5 reports the
// retry.
//
// Ports:
//   CLK                 system clock
//   RESET               asynchronous, active-low reset
//   Port_ID             PicoBlaze port address
//   Write_Strobe        PicoBlaze write strobe; a write to PORT_DATA starts a frame
//   Out_Port            PicoBlaze write data (the command byte)
//   Read_Strobe         PicoBlaze read strobe; a read of PORT_STATUS clears sticky bits
//   Status_Output       registered status byte:
//                       {2'b0, retried, overrun, timeout, ack_err, done, busy}
//   PS2_Clock_In        PS/2 clock pin level (asynchronous)
//   PS2_Data_In         PS/2 data pin level (asynchronous)
//   PS2_Clock_Drive_Low 1 = pull the PS/2 clock low
//   PS2_Data_Drive_Low  1 = pull the PS/2 data low
//   Tx_Busy             1 while a transmission is in progress (receiver ignores the bus)
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter logic [7:0]  PORT_DATA      = 8'h08,
  parameter logic [7:0]  PORT_STATUS    = 8'h09,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Port_ID,
  input  logic       Write_Strobe,
  input  logic [7:0] Out_Port,
  input  logic       Read_Strobe,
  output logic [7:0] Status_Output,
  input  logic       PS2_Clock_In,
  input  logic       PS2_Data_In,
  output logic       PS2_Clock_Drive_Low,
  output logic       PS2_Data_Drive_Low,
  output logic       Tx_Busy
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                    INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_STOP,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   clk_drive_q, clk_drive_d;
  logic                   data_drive_q, data_drive_d;
  logic                   busy_q, busy_d;
  logic                   ack_ok_q, ack_ok_d;
  logic                   done_q, done_d;
  logic                   ack_err_q, ack_err_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             status_q, status_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
`ifdef PS2_TX_RETRY_EN
  logic                   retry_used_q, retry_used_d;
  logic                   retried_q, retried_d;
  logic                   set_retried;
`endif

  logic clk_s, data_s, fall;
  logic wr_data, rd_status, start;
  logic timed_out;
  logic set_done, set_ack_err, set_timeout;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  assign wr_data   = Write_Strobe && (Port_ID == PORT_DATA);
  assign rd_status = Read_Strobe && (Port_ID == PORT_STATUS);
  assign timed_out = (cnt_q == TO_LAST);

  assign PS2_Clock_Drive_Low = clk_drive_q;
  assign PS2_Data_Drive_Low  = data_drive_q;
  assign Tx_Busy             = busy_q;
  assign Status_Output       = status_q;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_Clock_In};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], PS2_Data_In};
    clk_prev_d  = clk_s;
  end

  // Next-state, counters and line drive.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_byte_d    = tx_byte_q;
    data_drive_d = data_drive_q;
    ack_ok_d     = ack_ok_q;
    start        = 1'b0;
    set_done     = 1'b0;
    set_ack_err  = 1'b0;
    set_timeout  = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_used_d = retry_used_q;
    set_retried  = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        data_drive_d = 1'b0;
        if (wr_data) begin
          tx_byte_d = Out_Port;
          cnt_d     = '0;
          start     = 1'b1;
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_used_d = 1'b0;
`endif
        end
      end

      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RTS, S_DATA, S_STOP, S_ACK: begin
        if (timed_out) begin
          data_drive_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
          if (!retry_used_q) begin
            retry_used_d = 1'b1;
            set_retried  = 1'b1;
            cnt_d        = '0;
            state_d      = S_INHIBIT;
          end else
`endif
          begin
            set_timeout = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          unique case (state_q)
            S_RTS: begin
              // Start bit is the held-low data line itself.
              data_drive_d = 1'b1;
              if (fall) begin
                data_drive_d = ~tx_byte_q[0];
                bit_cnt_d    = 4'd1;
                state_d      = S_DATA;
              end
            end
            S_DATA: begin
              if (fall) begin
                if (bit_cnt_q == 4'd8) begin
                  // Odd parity bit is ~^byte, so its drive-low is ^byte.
                  data_drive_d = ^tx_byte_q;
                  state_d      = S_STOP;
                end else begin
                  data_drive_d = ~tx_byte_q[bit_cnt_q[2:0]];
                  bit_cnt_d    = bit_cnt_q + 4'd1;
                end
              end
            end
            S_STOP: begin
              if (fall) begin
                data_drive_d = 1'b0;
                state_d      = S_ACK;
              end
            end
            default: begin
              if (fall) begin
                if (!data_s) begin
                  ack_ok_d = 1'b1;
                  state_d  = S_WAIT_IDLE;
                end else begin
`ifdef PS2_TX_RETRY_EN
                  if (!retry_used_q) begin
                    retry_used_d = 1'b1;
                    set_retried  = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_INHIBIT;
                  end else
`endif
                  begin
                    ack_ok_d    = 1'b0;
                    set_ack_err = 1'b1;
                    state_d     = S_WAIT_IDLE;
                  end
                end
              end
            end
          endcase
        end
      end

      S_WAIT_IDLE: begin
        data_drive_d = 1'b0;
        if (clk_s && data_s) begin
          // done reports an acknowledged frame; a NACKed one only waits for idle.
          set_done = ack_ok_q;
          state_d  = S_IDLE;
        end
      end

      default: begin
        data_drive_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase

    // Line drives are registered from the next state so they change with it.
    clk_drive_d = (state_d == S_INHIBIT);
    if (state_d == S_INHIBIT) begin
      data_drive_d = (cnt_d == INH_LAST);
    end
    busy_d = (state_d != S_IDLE);
  end

  // Sticky status bits: read clears, set wins over clear.
  always_comb begin
    done_d    = done_q;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (rd_status || start) begin
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;
    end
    if (rd_status) begin
      overrun_d = 1'b0;
    end
    if (set_done)    done_d    = 1'b1;
    if (set_ack_err) ack_err_d = 1'b1;
    if (set_timeout) timeout_d = 1'b1;
    if (wr_data && (state_q != S_IDLE)) overrun_d = 1'b1;
`ifdef PS2_TX_RETRY_EN
    retried_d = retried_q;
    if (rd_status)   retried_d = 1'b0;
    if (set_retried) retried_d = 1'b1;
`endif
  end

  always_comb begin
    status_d = '0;
    if (Port_ID == PORT_STATUS) begin
`ifdef PS2_TX_RETRY_EN
      status_d = {2'b00, retried_q, overrun_q, timeout_q, ack_err_q, done_q, busy_q};
`else
      status_d = {3'b000, overrun_q, timeout_q, ack_err_q, done_q, busy_q};
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      tx_byte_q    <= '0;
      clk_drive_q  <= 1'b0;
      data_drive_q <= 1'b0;
      busy_q       <= 1'b0;
      ack_ok_q     <= 1'b0;
      done_q       <= 1'b0;
      ack_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      status_q     <= '0;
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retry_used_q <= 1'b0;
      retried_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_byte_q    <= tx_byte_d;
      clk_drive_q  <= clk_drive_d;
      data_drive_q <= data_drive_d;
      busy_q       <= busy_d;
      ack_ok_q     <= ack_ok_d;
      done_q       <= done_d;
      ack_err_q    <= ack_err_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      status_q     <= status_d;
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
`ifdef PS2_TX_RETRY_EN
      retry_used_q <= retry_used_d;
      retried_q    <= retried_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: PS/2 device model on open-drain lines,
// scoreboard queues for frame bits and status reads.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 2000;
  localparam int unsigned HALF = 12;

  // Frames as {stop, parity, b7..b0, start}, hand-written.
  localparam logic [10:0] FRAME_ED = 11'b1_1_11101101_0;
  localparam logic [10:0] FRAME_F4 = 11'b1_0_11110100_0;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] Port_ID = 8'h00;
  logic       Write_Strobe = 1'b0;
  logic [7:0] Out_Port = 8'h00;
  logic       Read_Strobe = 1'b0;
  logic [7:0] Status_Output;
  logic       PS2_Clock_Drive_Low;
  logic       PS2_Data_Drive_Low;
  logic       Tx_Busy;

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(PS2_Clock_Drive_Low | dev_clk_low);
  assign ps2_data_line = ~(PS2_Data_Drive_Low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .PORT_DATA(8'h08),
    .PORT_STATUS(8'h09),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .Port_ID(Port_ID),
    .Write_Strobe(Write_Strobe),
    .Out_Port(Out_Port),
    .Read_Strobe(Read_Strobe),
    .Status_Output(Status_Output),
    .PS2_Clock_In(ps2_clk_line),
    .PS2_Data_In(ps2_data_line),
    .PS2_Clock_Drive_Low(PS2_Clock_Drive_Low),
    .PS2_Data_Drive_Low(PS2_Data_Drive_Low),
    .Tx_Busy(Tx_Busy)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        exp_bits[$];
  logic [7:0]  exp_stat[$];
  event        bit_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-bit monitor: the device model signals each sampling instant.
  initial begin : mon_bits
    logic e;
    forever begin
      @(bit_ev);
      if (exp_bits.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL frame_bit: got unexpected sample %b, expected none", ps2_data_line);
      end else begin
        e = exp_bits.pop_front();
        check("frame_bit", {31'd0, ps2_data_line}, {31'd0, e});
      end
    end
  end

  // Status monitor: a status read presents its byte after the read edge.
  initial begin : mon_stat
    logic       rd;
    logic [7:0] e;
    forever begin
      @(posedge CLK);
      rd = Read_Strobe && (Port_ID == 8'h09);
      if (rd) begin
        @(negedge CLK);
        if (exp_stat.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL status_read: got %0h, expected none", Status_Output);
        end else begin
          e = exp_stat.pop_front();
          check("status_read", {24'd0, Status_Output}, {24'd0, e});
        end
      end
    end
  end

  task automatic write_port(input logic [7:0] id, input logic [7:0] val);
    @(posedge CLK); #1;
    Port_ID = id; Out_Port = val; Write_Strobe = 1'b1;
    @(posedge CLK); #1;
    Write_Strobe = 1'b0; Port_ID = 8'h00;
  endtask

  task automatic read_status(input logic [7:0] expv);
    exp_stat.push_back(expv);
    @(posedge CLK); #1;
    Port_ID = 8'h09; Read_Strobe = 1'b1;
    @(posedge CLK); #1;
    Read_Strobe = 1'b0; Port_ID = 8'h00;
  endtask

  // Device: measures inhibit, clocks 11 edges, ACKs (or not) on edge 11.
  task automatic device_frame(input logic nack, input logic [10:0] frame);
    int unsigned n, nd, w;
    for (int i = 0; i < 11; i++) exp_bits.push_back(frame[i]);
    n = 0; nd = 0;
    @(negedge CLK);
    while (PS2_Clock_Drive_Low && n < INH + 50) begin
      n++;
      if (PS2_Data_Drive_Low) nd++;
      @(negedge CLK);
    end
    check("inhibit_len", n, INH);
    check("inhibit_data_cycles", nd, 1);
    check("rts_data_low", {31'd0, PS2_Data_Drive_Low}, 32'd1);
    -> bit_ev;
    repeat (HALF) @(negedge CLK);
    for (int e = 1; e <= 10; e++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge CLK);
      -> bit_ev;
      dev_clk_low = 1'b0;
      repeat (HALF / 2) @(negedge CLK);
    end
    dev_data_low = ~nack;
    repeat (HALF / 2) @(negedge CLK);
    check("busy_in_frame", {31'd0, Tx_Busy}, 32'd1);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge CLK);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge CLK);
    dev_data_low = 1'b0;
    w = 0;
    while (Tx_Busy && w < 100) begin
      w++;
      @(negedge CLK);
    end
    check("busy_release", {31'd0, Tx_Busy}, 32'd0);
    check("lines_idle", {30'd0, ps2_clk_line, ps2_data_line}, 32'd3);
  endtask

  initial begin : stim
    int unsigned n, w;
    #2 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_drives", {30'd0, PS2_Clock_Drive_Low, PS2_Data_Drive_Low}, 32'd0);
    check("reset_busy", {31'd0, Tx_Busy}, 32'd0);
    check("reset_status", {24'd0, Status_Output}, 32'd0);
    RESET = 1'b1;
    read_status(8'h00);

    // Reset in the middle of INHIBIT.
    write_port(8'h08, 8'hED);
    Port_ID = 8'h09;
    repeat (10) @(posedge CLK);
    #1;
    check("inhibit_clk_low", {31'd0, PS2_Clock_Drive_Low}, 32'd1);
    check("inhibit_status_busy", {24'd0, Status_Output}, 32'h01);
    #2 RESET = 1'b0;
    #1;
    check("midreset_drives", {30'd0, PS2_Clock_Drive_Low, PS2_Data_Drive_Low}, 32'd0);
    check("midreset_status", {24'd0, Status_Output}, 32'd0);
    check("midreset_busy", {31'd0, Tx_Busy}, 32'd0);
    @(posedge CLK); #1;
    Port_ID = 8'h00;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);

    // ED, ACKed.
    write_port(8'h08, 8'hED);
    check("busy_after_write", {31'd0, Tx_Busy}, 32'd1);
    device_frame(1'b0, FRAME_ED);
    read_status(8'h02);
    read_status(8'h00);

    // F4, ACKed; busy checked around the write.
    check("idle_before_f4", {31'd0, Tx_Busy}, 32'd0);
    write_port(8'h08, 8'hF4);
    check("busy_after_f4_write", {31'd0, Tx_Busy}, 32'd1);
    device_frame(1'b0, FRAME_F4);
    read_status(8'h02);

    // ED, device leaves data high on edge 11.
    write_port(8'h08, 8'hED);
    device_frame(1'b1, FRAME_ED);
    read_status(8'h04);

    // Device never clocks: timeout after TO cycles from the clock release.
    write_port(8'h08, 8'hF4);
    w = 0;
    @(negedge CLK);
    while (PS2_Clock_Drive_Low && w < INH + 10) begin
      w++;
      @(negedge CLK);
    end
    n = 0;
    while (Tx_Busy && n < TO + 100) begin
      n++;
      @(negedge CLK);
    end
    check("timeout_len", n, TO);
    check("timeout_drives", {30'd0, PS2_Clock_Drive_Low, PS2_Data_Drive_Low}, 32'd0);
    read_status(8'h08);

    // Second write during an ED frame.
    write_port(8'h08, 8'hED);
    fork
      device_frame(1'b0, FRAME_ED);
      begin
        repeat (100) @(posedge CLK);
        write_port(8'h08, 8'hFF);
      end
    join
    read_status(8'h12);
    read_status(8'h00);

    repeat (4) @(posedge CLK);
    check("bits_drained", exp_bits.size(), 0);
    check("status_drained", exp_stat.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
